// File: rtl/scb_top_sim_pkg.sv
// Shared constants and types for the symbol crossbar.
//   c_IDLE_LANE   : value driven on a transmit lane with no source (K28.5, D16.2)
//   c_COMMA       : upper data byte that, with k[1] set, marks a comma
//   c_LINK_RELOAD : link timer reload value on each comma
//   c_REG_*       : register byte offsets (word index = offset[7:2])
//   port_cfg_t    : per-port routing configuration record
package scb_top_sim_pkg;

  localparam logic [17:0] c_IDLE_LANE   = 18'h2BC50;
  localparam logic [7:0]  c_COMMA       = 8'hBC;
  localparam logic [5:0]  c_LINK_RELOAD = 6'd63;

  localparam logic [7:0] c_REG_CTRL      = 8'h00;
  localparam logic [7:0] c_REG_IRQ_STAT  = 8'h04;
  localparam logic [7:0] c_REG_IRQ_MASK  = 8'h08;
  localparam logic [7:0] c_REG_PPS_CNT   = 8'h0C;
  localparam logic [7:0] c_REG_PORT_CFG  = 8'h40;
  localparam logic [7:0] c_REG_PORT_STAT = 8'h80;

  typedef struct packed {
    logic       loop;
    logic       route_en;
    logic [3:0] dst;
  } port_cfg_t;

  function automatic logic [5:0] reg_word(input logic [7:0] ofs);
    return ofs[7:2];
  endfunction

endpackage

// File: rtl/scb_port_lane.sv
// One transmit/receive lane of the crossbar.
//   clk, rst_n : clock and synchronous active-low reset
//   rd_all     : every receive lane, 18 bits each
//   loop       : this lane's loopback enable
//   en         : global routing enable
//   hit        : hit[s] = source s is routed to this lane
//   td         : registered transmit lane
//   link       : link indicator (timer non-zero)
//   link_evt   : one-cycle pulse on any link change
//   comma_cnt  : wrapping count of commas received on this lane
module scb_port_lane
  import scb_top_sim_pkg::*;
#(
  parameter int g_num_ports = 6,
  parameter int g_index     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [18*g_num_ports-1:0] rd_all,
  input  logic                      loop,
  input  logic                      en,
  input  logic [g_num_ports-1:0]    hit,
  output logic [17:0]               td,
  output logic                      link,
  output logic                      link_evt,
  output logic [15:0]               comma_cnt
);

  logic       comma;
  logic [5:0] timer;
  logic       link_q;
  logic [17:0] sel;

  // k[1] qualifies the upper data byte.
  assign comma = rd_all[18*g_index+17] &&
                 (rd_all[18*g_index+8 +: 8] == c_COMMA);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer     <= '0;
      link_q    <= 1'b0;
      comma_cnt <= '0;
      td        <= c_IDLE_LANE;
    end else begin
      if (comma)
        timer <= c_LINK_RELOAD;
      else if (timer != 6'd0)
        timer <= timer - 6'd1;
      link_q <= link;
      if (comma)
        comma_cnt <= comma_cnt + 16'd1;
      td <= sel;
    end
  end

  assign link     = (timer != 6'd0);
  assign link_evt = link ^ link_q;

  // Loopback first; otherwise the lowest routed source. Scanning downward
  // lets the lowest index take the final assignment.
  always_comb begin
    sel = c_IDLE_LANE;
    if (loop) begin
      sel = rd_all[18*g_index +: 18];
    end else if (en) begin
      for (int s = g_num_ports - 1; s >= 0; s--) begin
        if (hit[s])
          sel = rd_all[18*s +: 18];
      end
    end
  end

endmodule

// File: rtl/scb_top_sim.sv
// Symbol crossbar with Wishbone register file, link monitoring and PPS counter.
//   clk_sys_i, sys_rst_n_i : clock and synchronous active-low reset
//   wb_*                   : pipelined Wishbone slave, ack one cycle after strobe, never stalls
//   wb_irq_o               : registered OR of enabled interrupt status bits
//   pps_i                  : pulse-per-second input, rising edges are counted
//   rd_i / td_o            : receive / transmit lanes, {k[1:0], data[15:0]} per lane
// Valid/ready: an access is taken on every cycle with wb_cyc_i & wb_stb_i
// (stall is always 0); its ack and read data appear on the next cycle.
module scb_top_sim
  import scb_top_sim_pkg::*;
#(
  parameter int g_num_ports = 6
) (
  input  logic                      clk_sys_i,
  input  logic                      sys_rst_n_i,
  input  logic [31:0]               wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [3:0]                wb_sel_i,
  output logic                      wb_ack_o,
  output logic                      wb_stall_o,
  output logic                      wb_irq_o,
  input  logic                      pps_i,
  input  logic [18*g_num_ports-1:0] rd_i,
  output logic [18*g_num_ports-1:0] td_o
);

  logic                   acc;
  logic                   wr;
  logic [5:0]             word;
  logic                   ctrl_en;
  logic [g_num_ports-1:0] irq_stat;
  logic [g_num_ports-1:0] irq_mask;
  logic [g_num_ports-1:0] irq_clr;
  logic [31:0]            pps_cnt;
  logic                   pps_q;
  port_cfg_t [g_num_ports-1:0] cfg;
  logic [g_num_ports-1:0] link;
  logic [g_num_ports-1:0] link_evt;
  logic [15:0]            comma_cnt [g_num_ports];
  logic [31:0]            rdata;
  logic                   unused_bits;

  // Byte lanes are ignored and only address bits [7:2] decode.
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i};

  assign acc        = wb_cyc_i & wb_stb_i;
  assign wr         = acc & wb_we_i;
  assign word       = wb_adr_i[7:2];
  assign wb_stall_o = 1'b0;

  assign irq_clr = (wr && word == reg_word(c_REG_IRQ_STAT)) ?
                   wb_dat_i[g_num_ports-1:0] : '0;

  always_ff @(posedge clk_sys_i) begin
    if (!sys_rst_n_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      wb_irq_o <= 1'b0;
      ctrl_en  <= 1'b0;
      irq_stat <= '0;
      irq_mask <= '0;
      pps_cnt  <= '0;
      pps_q    <= 1'b0;
      cfg      <= '0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= (acc && !wb_we_i) ? rdata : 32'd0;
      wb_irq_o <= |(irq_stat & irq_mask);
      // A link event in the same cycle as a clear keeps the bit set.
      irq_stat <= link_evt | (irq_stat & ~irq_clr);
      pps_q    <= pps_i;
      if (pps_i && !pps_q)
        pps_cnt <= pps_cnt + 32'd1;
      if (wr && word == reg_word(c_REG_CTRL))
        ctrl_en <= wb_dat_i[0];
      if (wr && word == reg_word(c_REG_IRQ_MASK))
        irq_mask <= wb_dat_i[g_num_ports-1:0];
      for (int p = 0; p < g_num_ports; p++) begin
        if (wr && word == reg_word(c_REG_PORT_CFG) + 6'(p))
          cfg[p] <= port_cfg_t'(wb_dat_i[5:0]);
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      reg_word(c_REG_CTRL):     rdata[0] = ctrl_en;
      reg_word(c_REG_IRQ_STAT): rdata[g_num_ports-1:0] = irq_stat;
      reg_word(c_REG_IRQ_MASK): rdata[g_num_ports-1:0] = irq_mask;
      reg_word(c_REG_PPS_CNT):  rdata = pps_cnt;
      default: ;
    endcase
    for (int p = 0; p < g_num_ports; p++) begin
      if (word == reg_word(c_REG_PORT_CFG) + 6'(p))
        rdata = {26'd0, cfg[p]};
      if (word == reg_word(c_REG_PORT_STAT) + 6'(p))
        rdata = {comma_cnt[p], 15'd0, link[p]};
    end
  end

  for (genvar p = 0; p < g_num_ports; p++) begin : g_lane
    logic [g_num_ports-1:0] hit;
    // A DST beyond the last port matches no lane, so that source drives nothing.
    for (genvar s = 0; s < g_num_ports; s++) begin : g_hit
      assign hit[s] = cfg[s].route_en && (cfg[s].dst == 4'(p));
    end
    scb_port_lane #(
      .g_num_ports(g_num_ports),
      .g_index    (p)
    ) u_lane (
      .clk      (clk_sys_i),
      .rst_n    (sys_rst_n_i),
      .rd_all   (rd_i),
      .loop     (cfg[p].loop),
      .en       (ctrl_en),
      .hit      (hit),
      .td       (td_o[18*p +: 18]),
      .link     (link[p]),
      .link_evt (link_evt[p]),
      .comma_cnt(comma_cnt[p])
    );
  end

endmodule

// File: tb/tb_scb_top_sim.sv
// Self-checking bench for scb_top_sim: register access, link monitor,
// interrupts, routing priority, PPS counting and back-to-back bus access.
module tb_scb_top_sim;

  localparam int N = 6;
  localparam logic [17:0] IDLE = 18'h2BC50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic [31:0]     wb_adr = '0;
  logic [31:0]     wb_dat = '0;
  logic [31:0]     wb_dat_o;
  logic            wb_cyc = 1'b0;
  logic            wb_stb = 1'b0;
  logic            wb_we  = 1'b0;
  logic [3:0]      wb_sel = 4'hF;
  logic            wb_ack_o;
  logic            wb_stall_o;
  logic            wb_irq_o;
  logic            pps = 1'b0;
  logic [18*N-1:0] rd = '0;
  logic [18*N-1:0] td_o;

  scb_top_sim #(.g_num_ports(N)) dut (
    .clk_sys_i  (clk),
    .sys_rst_n_i(rst_n),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_dat),
    .wb_dat_o   (wb_dat_o),
    .wb_cyc_i   (wb_cyc),
    .wb_stb_i   (wb_stb),
    .wb_we_i    (wb_we),
    .wb_sel_i   (wb_sel),
    .wb_ack_o   (wb_ack_o),
    .wb_stall_o (wb_stall_o),
    .wb_irq_o   (wb_irq_o),
    .pps_i      (pps),
    .rd_i       (rd),
    .td_o       (td_o)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model state ----------------
  logic       m_loop  [16];
  logic       m_route [16];
  logic [3:0] m_dst   [16];
  logic       m_en;
  logic [17:0] exp_q[$];

  // Transmit lane p: loopback wins, then the lowest source routed to p, else idle.
  function automatic logic [17:0] model_td(input int p);
    if (m_loop[p]) return rd[18*p +: 18];
    if (m_en)
      for (int s = 0; s < N; s++)
        if (m_route[s] && int'(m_dst[s]) == p) return rd[18*s +: 18];
    return IDLE;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_dat = dat;
    step();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    checks++;
    if (wb_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL wr_ack adr=%h: ack=%b, required 1", adr, wb_ack_o);
    end
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr;
    step();
    wb_cyc = 1'b0; wb_stb = 1'b0;
    checks++;
    if (wb_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_ack adr=%h: ack=%b, required 1", adr, wb_ack_o);
    end
    dat = wb_dat_o;
  endtask

  task automatic cfg_write(input int p, input logic [31:0] val);
    wb_write(32'h40 + 32'(4 * p), val);
    if (p < N) begin
      m_dst[p]   = val[3:0];
      m_route[p] = val[4];
      m_loop[p]  = val[5];
    end
  endtask

  task automatic set_lane(input int p, input logic [17:0] v);
    rd[18*p +: 18] = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    for (int i = 0; i < 16; i++) begin
      m_loop[i] = 1'b0; m_route[i] = 1'b0; m_dst[i] = 4'd0;
    end
    m_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    // Strobe coincides with reset: the access must be dropped.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 32'h0; rst_n = 1'b0;
    step();
    wb_cyc = 1'b0; wb_stb = 1'b0; rst_n = 1'b1;
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_access: ack=%b, required 0", wb_ack_o);
    end
    step();
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++; $display("FAIL rst_no_late_ack: ack=%b, required 0", wb_ack_o);
    end
    checks++;
    if (wb_irq_o !== 1'b0 || wb_stall_o !== 1'b0) begin
      errors++; $display("FAIL rst_irq_stall: irq=%b stall=%b, required 0 0", wb_irq_o, wb_stall_o);
    end
    for (int p = 0; p < N; p++) begin
      checks++;
      if (td_o[18*p +: 18] !== IDLE) begin
        errors++; $display("FAIL rst_td lane=%0d: got %h, required %h", p, td_o[18*p +: 18], IDLE);
      end
    end
    for (int a = 0; a < 4; a++) begin
      wb_read(32'(4 * a), d);
      checks++;
      if (d !== 32'd0) begin
        errors++; $display("FAIL rst_reg adr=%h: got %h, required 0", 4 * a, d);
      end
    end
    for (int p = 0; p < N; p++) begin
      wb_read(32'h40 + 32'(4 * p), d);
      checks++;
      if (d !== 32'd0) begin
        errors++; $display("FAIL rst_cfg p=%0d: got %h, required 0", p, d);
      end
      wb_read(32'h80 + 32'(4 * p), d);
      checks++;
      if (d !== 32'd0) begin
        errors++; $display("FAIL rst_stat p=%0d: got %h, required 0", p, d);
      end
    end
  endtask

  task automatic test_link_up();
    logic [31:0] d;
    set_lane(0, IDLE);
    repeat (3) step();
    set_lane(0, 18'h00000);
    wb_read(32'h80, d);
    checks++;
    if (d !== 32'h0003_0001) begin
      errors++; $display("FAIL link_up_stat: got %h, required 00030001", d);
    end
    wb_read(32'h04, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL link_up_irq_stat: got %h, required 1", d);
    end
    wb_write(32'h08, 32'h1);
    step();
    checks++;
    if (wb_irq_o !== 1'b1) begin
      errors++; $display("FAIL irq_assert: irq=%b, required 1", wb_irq_o);
    end
    wb_write(32'h04, 32'h1);
    step();
    checks++;
    if (wb_irq_o !== 1'b0) begin
      errors++; $display("FAIL irq_clear: irq=%b, required 0", wb_irq_o);
    end
  endtask

  task automatic test_link_down();
    logic [31:0] d;
    logic [31:0] expv;
    // One more comma, then silence; stream reads of PORT_STAT[0] every cycle.
    set_lane(0, IDLE);
    step();
    set_lane(0, 18'h00000);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h80;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 70) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
      // Read data registered at this edge shows the state k-1 cycles after
      // the last comma; the link holds while fewer than 63 cycles have passed.
      expv = {16'd4, 15'd0, (k - 1 < 63) ? 1'b1 : 1'b0};
      checks++;
      if (wb_ack_o !== 1'b1 || wb_dat_o !== expv) begin
        errors++;
        $display("FAIL link_down k=%0d: ack=%b dat=%h, required ack=1 dat=%h", k, wb_ack_o, wb_dat_o, expv);
      end
    end
    step();
    wb_read(32'h04, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL link_down_irq_stat: got %h, required 1", d);
    end
    checks++;
    if (wb_irq_o !== 1'b1) begin
      errors++; $display("FAIL link_down_irq: irq=%b, required 1", wb_irq_o);
    end
    wb_write(32'h04, 32'hFFFF_FFFF);
    wb_write(32'h08, 32'h0);
  endtask

  task automatic test_route();
    wb_write(32'h00, 32'h1);
    m_en = 1'b1;
    cfg_write(2, 32'h13);
    set_lane(2, 18'h01234);
    checks++;
    if (td_o[18*3 +: 18] !== IDLE) begin
      errors++; $display("FAIL route_latency: lane3=%h, required %h", td_o[18*3 +: 18], IDLE);
    end
    step();
    checks++;
    if (td_o[18*3 +: 18] !== 18'h01234) begin
      errors++; $display("FAIL route_2to3: lane3=%h, required 01234", td_o[18*3 +: 18]);
    end
    for (int p = 0; p < N; p++) begin
      checks++;
      if (td_o[18*p +: 18] !== model_td(p)) begin
        errors++; $display("FAIL route_all lane=%0d: got %h, required %h", p, td_o[18*p +: 18], model_td(p));
      end
    end
  endtask

  task automatic test_loop_priority();
    logic [17:0] v1;
    logic [17:0] v3;
    cfg_write(1, 32'h13);
    cfg_write(2, 32'h13);
    cfg_write(3, 32'h20);
    v1 = 18'($urandom_range(0, 32'h3FFFF));
    v3 = 18'($urandom_range(0, 32'h3FFFF));
    set_lane(1, v1);
    set_lane(2, 18'($urandom_range(0, 32'h3FFFF)));
    set_lane(3, v3);
    step();
    checks++;
    if (td_o[18*3 +: 18] !== v3) begin
      errors++; $display("FAIL loop_priority: lane3=%h, required %h", td_o[18*3 +: 18], v3);
    end
    cfg_write(3, 32'h00);
    step();
    checks++;
    if (td_o[18*3 +: 18] !== v1) begin
      errors++; $display("FAIL lowest_source: lane3=%h, required %h", td_o[18*3 +: 18], v1);
    end
  endtask

  task automatic test_random();
    logic [17:0] e;
    for (int it = 0; it < 20; it++) begin
      m_en = 1'($urandom_range(0, 1));
      wb_write(32'h00, {31'd0, m_en});
      for (int p = 0; p < N; p++)
        cfg_write(p, 32'($urandom_range(0, 3) << 4) | 32'($urandom_range(0, 7)));
      for (int c = 0; c < 4; c++) begin
        for (int p = 0; p < N; p++) set_lane(p, 18'($urandom_range(0, 32'h3FFFF)));
        for (int p = 0; p < N; p++) exp_q.push_back(model_td(p));
        step();
        for (int p = 0; p < N; p++) begin
          e = exp_q.pop_front();
          checks++;
          if (td_o[18*p +: 18] !== e) begin
            errors++; $display("FAIL random it=%0d lane=%0d: got %h, required %h", it, p, td_o[18*p +: 18], e);
          end
        end
      end
    end
  endtask

  task automatic test_pps();
    int unsigned m_pps;
    logic [31:0] d;
    m_pps = 0;
    for (int i = 0; i < 3; i++) begin
      pps = 1'b1; m_pps++;
      repeat (1 + i) step();
      pps = 1'b0;
      repeat (2) step();
    end
    wb_read(32'h0C, d);
    checks++;
    if (d !== 32'(m_pps)) begin
      errors++; $display("FAIL pps_cnt: got %0d, required %0d", d, m_pps);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    wb_write(32'h40 + 32'(4 * N), 32'h3F);
    wb_read(32'h40 + 32'(4 * N), d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL oor_cfg: got %h, required 0", d);
    end
    wb_read(32'h80 + 32'(4 * N), d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL oor_stat: got %h, required 0", d);
    end
    wb_read(32'h10, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL unmapped: got %h, required 0", d);
    end
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h00;
    step();
    wb_adr = 32'h0C;
    checks++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== {31'd0, m_en}) begin
      errors++; $display("FAIL b2b_ctrl: ack=%b dat=%h, required 1 %h", wb_ack_o, wb_dat_o, {31'd0, m_en});
    end
    step();
    wb_cyc = 1'b0; wb_stb = 1'b0;
    checks++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'd3) begin
      errors++; $display("FAIL b2b_pps: ack=%b dat=%h, required 1 3", wb_ack_o, wb_dat_o);
    end
    step();
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: ack=%b, required 0", wb_ack_o);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_link_up();
    test_link_down();
    test_route();
    test_loop_priority();
    test_random();
    test_pps();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
